// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache write-back path: bus widths,
// address split, drain state encoding and RAM request levels.
package cache_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 3;
    localparam int SET_W  = 3;

    // Drain engine states: IDLE waits for work, WRITE holds a RAM request.
    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_e;

    // RAM write-request levels and the shortest possible drain turnaround.
    localparam logic MEM_REQ_OFF          = 1'b0;
    localparam logic MEM_REQ_ON           = 1'b1;
    localparam int   MEM_MIN_DRAIN_CYCLES = 2;
endpackage

// File: rtl/cache_writeback_buffer_if.sv
// Bus bundle between cache, write-back buffer and RAM. The buffer takes the
// slave view; whatever drives evictions, lookups and the RAM ack takes master.
interface cache_writeback_buffer_if #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              evict_valid;
    logic [ADDR_W-1:0] evict_addr;
    logic [DATA_W-1:0] evict_data;
    logic              evict_ready;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [DATA_W-1:0] lookup_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport slave (
        input  evict_valid, evict_addr, evict_data, lookup_addr, mem_ack,
        output evict_ready, lookup_hit, lookup_data, mem_we, mem_addr, mem_wdata,
               count, full, empty
    );

    modport master (
        output evict_valid, evict_addr, evict_data, lookup_addr, mem_ack,
        input  evict_ready, lookup_hit, lookup_data, mem_we, mem_addr, mem_wdata,
               count, full, empty
    );
endinterface

// File: rtl/cache_writeback_buffer_wb_queue.sv
// Circular store of buffered victims: allocation at tail, removal at head,
// in-place coalescing of repeated addresses and youngest-match lookup.
module wb_queue #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        push_i,
    input  logic [ADDR_W-1:0]           push_addr_i,
    input  logic [DATA_W-1:0]           push_data_i,
    input  logic                        pop_i,
    input  logic                        head_locked_i,
    input  logic [ADDR_W-1:0]           lookup_addr_i,
    output logic                        coalesce_hit_o,
    output logic                        coalesce_at_head_o,
    output logic [ADDR_W-1:0]           head_addr_o,
    output logic [DATA_W-1:0]           head_data_o,
    output logic                        lookup_hit_o,
    output logic [DATA_W-1:0]           lookup_data_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        full_o,
    output logic                        empty_o
);
    import cache_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              valid_q [DEPTH];
    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q, head_d, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  co_idx;
    logic              co_hit;
    logic              alloc;
    logic [DEPTH-1:0]  alloc_we, coal_we, pop_clr;

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx           = head_q;
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        co_hit        = 1'b0;
        co_idx        = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && valid_q[idx]) begin
                if (addr_q[idx] == lookup_addr_i) begin
                    lookup_hit_o  = 1'b1;
                    lookup_data_o = data_q[idx];
                end
                // The entry being written to RAM must not change under it.
                if ((addr_q[idx] == push_addr_i) && !(k == 0 && head_locked_i)) begin
                    co_hit = 1'b1;
                    co_idx = idx;
                end
            end
        end
    end

    assign alloc = push_i && !co_hit;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
        assign alloc_we[gi] = alloc && (tail_q == PTR_W'(gi));
        assign coal_we[gi]  = push_i && co_hit && (co_idx == PTR_W'(gi));
        assign pop_clr[gi]  = pop_i && (head_q == PTR_W'(gi));
    end

    assign head_d  = pop_i ? head_q + PTR_W'(1) : head_q;
    assign tail_d  = alloc ? tail_q + PTR_W'(1) : tail_q;
    assign count_d = count_q + CNT_W'(alloc) - CNT_W'(pop_i);

    // Pointer, occupancy and per-entry storage update.
    always_ff @(posedge clk) begin
        if (srst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (pop_clr[i]) valid_q[i] <= 1'b0;
                if (alloc_we[i]) begin
                    valid_q[i] <= 1'b1;
                    addr_q[i]  <= push_addr_i;
                end
                if (alloc_we[i] || coal_we[i]) data_q[i] <= push_data_i;
            end
        end
    end

    assign coalesce_hit_o     = co_hit;
    assign coalesce_at_head_o = co_hit && (co_idx == head_q);
    assign head_addr_o        = addr_q[head_q];
    assign head_data_o        = data_q[head_q];
    assign count_o            = count_q;
    assign full_o             = (count_q == CNT_W'(DEPTH));
    assign empty_o            = (count_q == '0);
endmodule

// File: rtl/cache_writeback_buffer.sv
// Write-back buffer top: victim queue plus the drain engine that replays
// queued victims into RAM one at a time over the ack handshake.
module cache_writeback_buffer #(
    parameter int ADDR_W = cache_pkg::ADDR_W,
    parameter int DATA_W = cache_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    Reset,
    cache_writeback_buffer_if.slave bus
);
    import cache_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    drain_state_e      state_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              evict_ready;
    logic              push, pop;
    logic              co_hit, co_at_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data, launch_data;
    logic [CNT_W-1:0]  count;
    logic              full, empty;

    // A full buffer still takes a victim that folds into an existing entry.
    assign evict_ready = !full || co_hit;
    assign push        = bus.evict_valid && evict_ready;
    assign pop         = (state_q == DRAIN_WRITE) && bus.mem_ack;

    wb_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_queue (
        .clk                (clk),
        .srst               (Reset),
        .push_i             (push),
        .push_addr_i        (bus.evict_addr),
        .push_data_i        (bus.evict_data),
        .pop_i              (pop),
        .head_locked_i      (state_q == DRAIN_WRITE),
        .lookup_addr_i      (bus.lookup_addr),
        .coalesce_hit_o     (co_hit),
        .coalesce_at_head_o (co_at_head),
        .head_addr_o        (head_addr),
        .head_data_o        (head_data),
        .lookup_hit_o       (bus.lookup_hit),
        .lookup_data_o      (bus.lookup_data),
        .count_o            (count),
        .full_o             (full),
        .empty_o            (empty)
    );

    // The head may be coalesced on the very edge we launch it; take the new data.
    assign launch_data = (push && co_at_head) ? bus.evict_data : head_data;

    // Drain engine: launch head from IDLE, hold request in WRITE until acked.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= DRAIN_IDLE;
            mem_we_q    <= MEM_REQ_OFF;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                DRAIN_IDLE: begin
                    if (!empty) begin
                        state_q     <= DRAIN_WRITE;
                        mem_we_q    <= MEM_REQ_ON;
                        mem_addr_q  <= head_addr;
                        mem_wdata_q <= launch_data;
                    end
                end
                DRAIN_WRITE: begin
                    if (bus.mem_ack) begin
                        state_q     <= DRAIN_IDLE;
                        mem_we_q    <= MEM_REQ_OFF;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end
                end
                default: begin
                    state_q  <= DRAIN_IDLE;
                    mem_we_q <= MEM_REQ_OFF;
                end
            endcase
        end
    end

    assign bus.evict_ready = evict_ready;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.count       = count;
    assign bus.full        = full;
    assign bus.empty       = empty;
endmodule

// File: tb/tb_cache_writeback_buffer.sv
// Bench for the write-back buffer: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of the buffer contents.
module tb_cache_writeback_buffer;
    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    cache_writeback_buffer_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

    cache_writeback_buffer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];       // buffered victims, oldest first
    bit            m_write;     // oldest entry currently offered to RAM
    logic [AW-1:0] dut_log[$];  // addresses the DUT completed to RAM
    bit            last_acc;
    int            n_checks = 0;
    int            n_errs   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Youngest entry holding address a, optionally ignoring the entry in flight.
    function automatic int m_find(input logic [AW-1:0] a, input bit skip_head);
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].a == a && !(skip_head && i == 0)) return i;
        return -1;
    endfunction

    function automatic bit m_ready(input logic [AW-1:0] a);
        return (mq.size() < DEPTH) || (m_find(a, m_write) >= 0);
    endfunction

    // One clock: drive, compare everything at the falling edge, advance model.
    task automatic cycle(input bit rst, input bit ev, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [AW-1:0] la, input bit ack);
        int   ci, li;
        bit   rdy, launch, drain;
        ent_t e;
        Reset           = rst;
        bus.evict_valid = ev;
        bus.evict_addr  = a;
        bus.evict_data  = d;
        bus.lookup_addr = la;
        bus.mem_ack     = ack;
        @(negedge clk);
        ci  = m_find(a, m_write);
        li  = m_find(la, 1'b0);
        rdy = m_ready(a);
        check_eq("evict_ready", {31'b0, bus.evict_ready}, {31'b0, rdy});
        check_eq("lookup_hit", {31'b0, bus.lookup_hit}, (li >= 0) ? 32'd1 : 32'd0);
        check_eq("lookup_data", {24'b0, bus.lookup_data}, (li >= 0) ? {24'b0, mq[li].d} : 32'd0);
        check_eq("count", {29'b0, bus.count}, mq.size());
        check_eq("full", {31'b0, bus.full}, (mq.size() == DEPTH) ? 32'd1 : 32'd0);
        check_eq("empty", {31'b0, bus.empty}, (mq.size() == 0) ? 32'd1 : 32'd0);
        check_eq("mem_we", {31'b0, bus.mem_we}, {31'b0, m_write});
        check_eq("mem_addr", {26'b0, bus.mem_addr}, m_write ? {26'b0, mq[0].a} : 32'd0);
        check_eq("mem_wdata", {24'b0, bus.mem_wdata}, m_write ? {24'b0, mq[0].d} : 32'd0);
        if (!rst && bus.mem_we && ack) dut_log.push_back(bus.mem_addr);
        @(posedge clk);
        #1;
        last_acc = !rst && ev && rdy;
        if (rst) begin
            mq.delete();
            m_write = 1'b0;
        end else begin
            launch = !m_write && (mq.size() != 0);
            drain  = m_write && ack;
            if (drain) $display("drain  addr=%h data=%h", mq[0].a, mq[0].d);
            if (last_acc) begin
                if (ci >= 0) begin
                    e = mq[ci];
                    e.d = d;
                    mq[ci] = e;
                end else begin
                    mq.push_back('{a: a, d: d});
                end
                $display("push   addr=%h data=%h %s", a, d, (ci >= 0) ? "merged" : "queued");
            end
            if (drain) begin
                void'(mq.pop_front());
                m_write = 1'b0;
            end else if (launch) begin
                m_write = 1'b1;
            end
        end
    endtask

    // Combinational-only peek at ready and lookup without clocking.
    task automatic probe(input logic [AW-1:0] ea, input logic [AW-1:0] la);
        int li;
        bus.evict_valid = 1'b0;
        bus.evict_addr  = ea;
        bus.lookup_addr = la;
        #1;
        li = m_find(la, 1'b0);
        check_eq("probe_ready", {31'b0, bus.evict_ready}, {31'b0, m_ready(ea)});
        check_eq("probe_hit", {31'b0, bus.lookup_hit}, (li >= 0) ? 32'd1 : 32'd0);
        check_eq("probe_data", {24'b0, bus.lookup_data}, (li >= 0) ? {24'b0, mq[li].d} : 32'd0);
    endtask

    initial begin
        int tries;
        Reset           = 1'b1;
        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.lookup_addr = '0;
        bus.mem_ack     = 1'b0;
        m_write         = 1'b0;

        // Reset state.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("rst_empty", {31'b0, bus.empty}, 32'd1);
        check_eq("rst_we", {31'b0, bus.mem_we}, 32'd0);

        // Single victim, acked on the third WRITE cycle.
        cycle(0, 1, 6'h0A, 8'h55, 6'h0A, 0);
        repeat (3) cycle(0, 0, 6'h00, 8'h00, 6'h0A, 0);
        check_eq("t1_wdata", {24'b0, bus.mem_wdata}, 32'h55);
        cycle(0, 0, 6'h00, 8'h00, 6'h0A, 1);
        check_eq("t1_we_off", {31'b0, bus.mem_we}, 32'd0);
        check_eq("t1_count", {29'b0, bus.count}, 32'd0);
        cycle(0, 0, 6'h00, 8'h00, 6'h0A, 0);

        // Fill to capacity, then coalesce into a non-head entry while full.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 1, AW'(i), DW'(8'h10 * i), AW'(i), 0);
        probe(6'h05, 6'h05);
        check_eq("full_ready05", {31'b0, bus.evict_ready}, 32'd0);
        probe(6'h03, 6'h03);
        check_eq("full_ready03", {31'b0, bus.evict_ready}, 32'd1);
        cycle(0, 1, 6'h03, 8'hAA, 6'h03, 0);
        probe(6'h00, 6'h03);
        check_eq("merge_data", {24'b0, bus.lookup_data}, 32'hAA);
        check_eq("merge_count", {29'b0, bus.count}, 32'd4);

        // Matching eviction while the head is in flight allocates a new entry.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 6'h01, 8'h11, 6'h01, 0);
        cycle(0, 0, 6'h00, 8'h00, 6'h01, 0);
        cycle(0, 1, 6'h01, 8'h77, 6'h01, 0);
        probe(6'h00, 6'h01);
        check_eq("inflight_lookup", {24'b0, bus.lookup_data}, 32'h77);
        check_eq("inflight_wdata", {24'b0, bus.mem_wdata}, 32'h11);
        check_eq("inflight_count", {29'b0, bus.count}, 32'd2);

        // Eight distinct victims streamed with ack always high; order preserved.
        cycle(1, 0, 0, 0, 0, 1);
        dut_log.delete();
        for (int i = 0; i < 8; i++) begin
            tries = 0;
            do begin
                cycle(0, 1, AW'(6'h10 + i), DW'(8'hC0 + i), AW'(6'h10 + i), 1);
                tries++;
            end while (!last_acc && tries < 20);
            if (!last_acc) check_eq("stream_push_timeout", 32'd0, 32'd1);
        end
        for (int t = 0; t < 40 && mq.size() != 0; t++) cycle(0, 0, 0, 0, 0, 1);
        check_eq("stream_empty", {31'b0, bus.empty}, 32'd1);
        check_eq("stream_nwrites", dut_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < dut_log.size(); i++)
            check_eq("stream_order", {26'b0, dut_log[i]}, 32'h10 + i);

        // Reset while a RAM write is pending with three entries held.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, AW'(6'h21 + i), DW'(8'h30 + i), 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check_eq("pre_rst_we", {31'b0, bus.mem_we}, 32'd1);
        check_eq("pre_rst_count", {29'b0, bus.count}, 32'd3);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("post_rst_we", {31'b0, bus.mem_we}, 32'd0);
        check_eq("post_rst_count", {29'b0, bus.count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            probe(0, AW'(6'h21 + i));
            check_eq("post_rst_hit", {31'b0, bus.lookup_hit}, 32'd0);
        end

        // Random traffic over a small address pool to provoke coalescing.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7)),
                  DW'($urandom),
                  AW'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_writeback_buffer.md
Name: cache_writeback_buffer

Overview:
- Write-back buffer between the 2-way set-associative data cache and the 64x8 RAM.
- Accepts dirty-victim evictions from the cache in one cycle and queues them.
- Drains them to RAM through a multi-cycle ack handshake, so eviction never stalls the processor.
- Provides a combinational lookup port so cache-miss refills see the newest buffered data before RAM has been updated.

Parameters:
- ADDR_W, 6, byte address width (3-bit tag + 3-bit set index).
- DATA_W, 8, data width.
- DEPTH, 4, entries in the buffer; power of two, at least 2.

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- evict_valid  in  1  cache presents a dirty victim
- evict_addr  in  ADDR_W  victim address {tag, set}
- evict_data  in  DATA_W  victim data
- evict_ready  out  1  buffer accepts the victim this cycle
- lookup_addr  in  ADDR_W  refill address from the cache miss path
- lookup_hit  out  1  buffered copy exists for lookup_addr
- lookup_data  out  DATA_W  newest buffered data for lookup_addr
- mem_we  out  1  RAM write request
- mem_addr  out  ADDR_W  RAM write address
- mem_wdata  out  DATA_W  RAM write data
- mem_ack  in  1  RAM has completed the write this cycle
- count  out  log2(DEPTH)+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Storage: circular queue with head pointer, tail pointer and count, plus per-entry valid, addr and data.
- Push: occurs when evict_valid && evict_ready at a rising clk edge.
- Coalescing:
  - A push whose evict_addr matches a valid entry that is not the in-flight head overwrites that entry's data in place.
  - Coalescing does not change count or tail.
  - If several entries match, the youngest is updated.
- evict_ready = !full || coalesce_match. It is combinational from evict_addr and registered state.
  - A pop in the same cycle does not free a slot for that cycle's push.
- Drain FSM, states IDLE and WRITE:
  - IDLE: if !empty, go to WRITE next cycle. mem_we = 0.
  - WRITE: mem_we = 1, mem_addr/mem_wdata = head entry, all stable until ack.
  - WRITE with mem_ack = 1: pop head at that edge and return to IDLE.
  - Minimum of 2 cycles per drained entry.
  - mem_ack is ignored in IDLE.
- The in-flight head is never coalesced into. A matching eviction during WRITE allocates a new tail entry, or is refused if full.
- Simultaneous push and pop: count unchanged, both pointers advance (modulo DEPTH, wrap-around).
- Lookup:
  - Combinational over all valid entries, including the in-flight head.
  - Youngest matching entry wins.
  - lookup_hit = 0 gives lookup_data = 0.
  - Lookup sees the buffer state before the current cycle's push.
- Reset values:
  - count = 0, empty = 1, full = 0, pointers = 0, all entries invalid.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0, state IDLE, lookup_hit = 0.
- Reset during WRITE: the pending RAM write is abandoned and mem_we drops in the cycle after the reset edge. The RAM tolerates a dropped request.
- Outputs mem_addr/mem_wdata are 0 whenever mem_we = 0.

Decomposition:
- Shared package cache_pkg holds:
  - ADDR_W, DATA_W, TAG_W = 3, SET_W = 3;
  - drain-state encoding (IDLE = 0, WRITE = 1);
  - the RAM handshake constants.
- One sub-module, wb_queue: storage, pointers, count, coalesce update and youngest-match lookup.
- The drain FSM and the RAM port stay in the top module.

Test Plan:
- Reset, then push {addr 6'h0A, data 8'h55} with mem_ack held 0 -> count = 1; mem_we = 1 from the second cycle after the push; mem_addr = 0A, mem_wdata = 55 held.
- Ack on cycle 3 of WRITE -> entry popped, count = 0, empty = 1, mem_we = 0 the next cycle.
- Fill 4 entries (addr 01..04) with ack low -> full = 1, evict_ready = 0 for addr 05, evict_ready = 1 for addr 03.
  - Push 03 with data AA -> count stays 4; lookup 03 returns AA.
- Head 01 in WRITE, push 01/data 77 -> new tail entry allocated; lookup 01 returns 77 while mem_wdata still shows the original data.
- Continuous pushes of 8 distinct addresses with ack on every WRITE cycle -> RAM receives all 8 in push order, pointers wrap past DEPTH, and no entry is lost or duplicated.
- Assert Reset while in WRITE with count = 3 -> next cycle mem_we = 0, count = 0, lookup_hit = 0 for all three addresses.
